// File: rtl/hand_command_decoder.sv
// hand_command_decoder
// Turns the per-frame finger-count stream into debounced enhancement
// commands: a count must persist STABLE_FRAMES frames to lock, a locked
// count survives up to DROP_FRAMES-1 consecutive mismatches, and held
// adjustment gestures (1..4) auto-repeat every REPEAT_FRAMES frames.
// Commands leave through a one-entry valid/ready holding register; a new
// command arriving while one is still pending is discarded.
// Optional build macro: HAND_CMD_DROP_CNT_EN enables the saturating
// discarded-command counter on dropped_out (tied to 0 otherwise).
module hand_command_decoder #(
    parameter int STABLE_FRAMES = 3,
    parameter int DROP_FRAMES   = 2,
    parameter int REPEAT_FRAMES = 10
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] count_in,
    input  logic       count_valid_in,
    output logic [2:0] cmd_out,
    output logic       cmd_valid_out,
    input  logic       cmd_ready_in,
    output logic       locked_out,
    output logic [3:0] stable_count_out,
    output logic [7:0] dropped_out
);

    localparam int RUN_W  = $clog2(STABLE_FRAMES + 1);
    localparam int MISS_W = $clog2(DROP_FRAMES + 1);
    localparam int HOLD_W = (REPEAT_FRAMES == 0) ? 1 : $clog2(REPEAT_FRAMES + 1);

    // "Last" values: the counter value seen on the frame that completes the run.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(STABLE_FRAMES - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(DROP_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((REPEAT_FRAMES == 0) ? 0 : REPEAT_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cand_q, cand_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               locked_q, locked_d;
    logic [3:0]         stable_q, stable_d;
    logic [2:0]         cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;

    logic [2:0]         frame_val;
    logic               gen_cmd;
    logic               accept;
    logic               drop_evt;

    // Out-of-range counts (6..15) are treated as "no hand".
    assign frame_val = (count_in <= 4'd5) ? count_in[2:0] : 3'd0;
    assign accept    = cmd_valid_q & cmd_ready_in;
    assign drop_evt  = gen_cmd & cmd_valid_q & ~cmd_ready_in;

    // Debounce FSM: next state, counters and command generation per frame.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        miss_d  = miss_q;
        hold_d  = hold_q;
        gen_cmd = 1'b0;
        if (count_valid_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_val != 3'd0) begin
                        cand_d = frame_val;
                        run_d  = RUN_W'(1);
                        if (STABLE_FRAMES == 1) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                            hold_d  = '0;
                            gen_cmd = 1'b1;
                        end else begin
                            state_d = ST_CANDIDATE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CANDIDATE: begin
                    if (frame_val == cand_q) begin
                        if (run_q != RUN_W'(STABLE_FRAMES)) begin
                            run_d = run_q + RUN_W'(1);
                        end else begin
                            run_d = run_q;
                        end
                        if (run_q >= RUN_LAST) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                            hold_d  = '0;
                            gen_cmd = 1'b1;
                        end else begin
                            state_d = ST_CANDIDATE;
                        end
                    end else if (frame_val != 3'd0) begin
                        cand_d = frame_val;
                        run_d  = RUN_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (frame_val == cand_q) begin
                        miss_d = '0;
                        if ((REPEAT_FRAMES != 0) && (cand_q <= 3'd4) && (hold_q >= HOLD_LAST)) begin
                            gen_cmd = 1'b1;
                            hold_d  = '0;
                        end else if (hold_q != HOLD_MAX) begin
                            hold_d = hold_q + HOLD_W'(1);
                        end else begin
                            hold_d = hold_q;
                        end
                    end else begin
                        if (miss_q >= MISS_LAST) begin
                            // Exiting frame is discarded, it does not seed a candidate.
                            state_d = ST_IDLE;
                            run_d   = '0;
                            miss_d  = '0;
                            hold_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                    miss_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Status outputs and the one-entry command holding register.
    always_comb begin
        locked_d    = (state_d == ST_LOCKED);
        stable_d    = locked_d ? {1'b0, cand_d} : 4'd0;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        if (gen_cmd && (!cmd_valid_q || accept)) begin
            cmd_d       = cand_d;
            cmd_valid_d = 1'b1;
        end else if (accept) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cand_q      <= 3'd0;
            run_q       <= '0;
            miss_q      <= '0;
            hold_q      <= '0;
            locked_q    <= 1'b0;
            stable_q    <= 4'd0;
            cmd_q       <= 3'd0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            hold_q      <= hold_d;
            locked_q    <= locked_d;
            stable_q    <= stable_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign cmd_out          = cmd_q;
    assign cmd_valid_out    = cmd_valid_q;
    assign locked_out       = locked_q;
    assign stable_count_out = stable_q;

`ifdef HAND_CMD_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of commands discarded by a busy holding register.
    always_comb begin
        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropped_out = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop_evt;
    assign dropped_out = 8'd0;
`endif

endmodule
